// File: rtl/mem_read_arbiter_if.sv
// Shared width package and the request/response bundle for mem_read_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
package core;
  parameter int ADDR_WIDTH = 16;
endpackage

interface mem_read_arbiter_if #(
  parameter int ADDR_WIDTH = core::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) ();
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport slave (
    input  req0_valid, req0_addr,
    input  req1_valid, req1_addr,
    input  mem_rsp_valid, mem_rsp_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data,
    output rsp1_valid, rsp1_data,
    output mem_req_valid, mem_req_addr
  );

  modport master (
    output req0_valid, req0_addr,
    output req1_valid, req1_addr,
    output mem_rsp_valid, mem_rsp_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data,
    input  rsp1_valid, rsp1_data,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter onto one in-order memory read port with a tag FIFO.
// Define MEM_READ_ARB_RR_EN for round-robin; default is fixed priority to req0.
`ifndef MSG
`define MSG(lvl, txt)
`endif

module mem_read_arbiter #(
  parameter int ADDR_WIDTH = core::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  mem_read_arbiter_if.slave bus
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH-1:0]  tags_q, tags_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;

  logic full;
  logic empty;
  logic slot;
  logic pop;
  logic push;
  logic drop;
  logic head_id;
  logic gnt_any;
  logic gnt_id;

  assign full    = (count_q == CW'(TAG_DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still takes a request when a response frees a tag this cycle
  assign slot    = !full || bus.mem_rsp_valid;
  assign pop     = bus.mem_rsp_valid && !empty;
  assign drop    = bus.mem_rsp_valid && empty;
  assign head_id = tags_q[rd_ptr_q];

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
`ifdef MEM_READ_ARB_RR_EN
    unique case (1'b1)
      bus.req0_valid && bus.req1_valid: begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant_q;
      end
      bus.req0_valid && !bus.req1_valid: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end
      !bus.req0_valid && bus.req1_valid: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
      default: ;
    endcase
`else
    unique case (1'b1)
      bus.req0_valid: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end
      !bus.req0_valid && bus.req1_valid: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  assign push           = !rst && slot && gnt_any;
  assign bus.req0_ready = push && !gnt_id;
  assign bus.req1_ready = push && gnt_id;

  always_comb begin
    mem_req_valid_d = push;
    mem_req_addr_d  = mem_req_addr_q;
    if (push) begin
      mem_req_addr_d = gnt_id ? bus.req1_addr : bus.req0_addr;
    end
  end

  always_comb begin
    tags_d = tags_q;
    if (push) begin
      tags_d[wr_ptr_q] = gnt_id;
    end
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    last_grant_d = push ? gnt_id : last_grant_q;
  end

  always_comb begin
    rsp0_valid_d = pop && !head_id;
    rsp1_valid_d = pop && head_id;
    rsp0_data_d  = rsp0_valid_d ? bus.mem_rsp_data : '0;
    rsp1_data_d  = rsp1_valid_d ? bus.mem_rsp_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      last_grant_q    <= 1'b1;
      mem_req_valid_q <= 1'b0;
      rsp0_valid_q    <= 1'b0;
      rsp1_valid_q    <= 1'b0;
    end else begin
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      last_grant_q    <= last_grant_d;
      mem_req_valid_q <= mem_req_valid_d;
      rsp0_valid_q    <= rsp0_valid_d;
      rsp1_valid_q    <= rsp1_valid_d;
      if (drop) begin
        `MSG(1, "mem_rsp with no outstanding read dropped");
      end
    end
  end

  // Payload registers carry no reset; their valids qualify them
  always_ff @(posedge clk) begin
    tags_q         <= tags_d;
    mem_req_addr_q <= mem_req_addr_d;
    rsp0_data_q    <= rsp0_data_d;
    rsp1_data_q    <= rsp1_data_d;
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.rsp0_valid    = rsp0_valid_q;
  assign bus.rsp0_data     = rsp0_data_q;
  assign bus.rsp1_valid    = rsp1_valid_q;
  assign bus.rsp1_data     = rsp1_data_q;

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default core::ADDR_WIDTH, word address width.
REQ-002 Parameter DATA_WIDTH, default 32, read data width.
REQ-003 Parameter TAG_DEPTH, default 4, maximum number of outstanding reads; power of two, at least 2.
REQ-004 clk  in  1  single clock for all state.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req0_valid / req0_addr / req0_ready  in / in / out  1 / ADDR_WIDTH / 1  read request from the ReadMem pipeline stage.
REQ-007 req1_valid / req1_addr / req1_ready  in / in / out  1 / ADDR_WIDTH / 1  read request from the debug/DMA requester.
REQ-008 rsp0_valid / rsp0_data  out / out  1 / DATA_WIDTH  read response to requester 0.
REQ-009 rsp1_valid / rsp1_data  out / out  1 / DATA_WIDTH  read response to requester 1.
REQ-010 mem_req_valid / mem_req_addr  out / out  1 / ADDR_WIDTH  request to the single shared memory read port; the port is always ready.
REQ-011 mem_rsp_valid / mem_rsp_data  in / in  1 / DATA_WIDTH  memory response; responses return in request order with arbitrary latency of 1 or more cycles.

Function
REQ-012 A request is accepted in a cycle when reqN_valid and reqN_ready are both 1; at most one request is accepted per cycle.
REQ-013 reqN_ready is combinational and is 1 only for the granted requester in a cycle where a slot is available.
REQ-014 A slot is available when outstanding count < TAG_DEPTH, or when count == TAG_DEPTH and mem_rsp_valid is 1 in the same cycle.
REQ-015 mem_req_valid and mem_req_addr are registered: one cycle after acceptance, mem_req_valid = 1 and mem_req_addr = the accepted address; mem_req_valid = 0 in cycles following no acceptance.
REQ-016 On acceptance, the requester id (0/1) is pushed into a TAG_DEPTH-entry in-order tag FIFO; pointers wrap modulo TAG_DEPTH.
REQ-017 On mem_rsp_valid, the head id is popped and the response is routed; rspN_valid/rspN_data are registered, one cycle after mem_rsp_valid; the rsp of the non-selected requester is 0.
REQ-018 A push and a pop in the same cycle leave the count unchanged; this is legal at count == TAG_DEPTH and at count == 0 only if a push from a prior cycle is pending (count > 0 for the pop).
REQ-019 mem_rsp_valid with count == 0 is dropped: no rspN_valid, state unchanged; in simulation, `MSG reports it at level 1.
REQ-020 Grant state: a 1-bit last_grant register, updated to the accepted id on each acceptance, held otherwise.

Reset
REQ-021 While rst = 1, the following hold on the next edge: count = 0, FIFO pointers = 0, last_grant = 1, and mem_req_valid, rsp0_valid, rsp1_valid = 0; data and address outputs are not reset.
REQ-022 Reset mid-operation discards all outstanding tags; memory responses arriving after reset are dropped per REQ-019.
REQ-023 req0_ready and req1_ready = 0 during any cycle with rst = 1.

Configuration
REQ-024 Macro MEM_READ_ARB_RR_EN, when defined: round-robin arbitration; when both requesters are valid, the requester != last_grant is granted; when only one is valid, that requester is granted.
REQ-025 When MEM_READ_ARB_RR_EN is not defined: fixed priority; requester 0 is always granted when valid; last_grant is still maintained but is not used.

Verification
REQ-026 Both requesters idle after reset -> ready0 = ready1 = 0, mem_req_valid = 0, no rsp for 10 cycles.
REQ-027 req0 addr 0x10 accepted at cycle t, mem_rsp with data 0xDEADBEEF at t+3 -> mem_req_valid/addr 0x10 at t+1, rsp0_valid with 0xDEADBEEF at t+4, rsp1_valid = 0.
REQ-028 Both valid for 4 cycles with RR_EN -> grants alternate 0,1,0,1 (last_grant = 1 after reset); without RR_EN -> grants 0,0,0,0 and ready1 = 0.
REQ-029 Four accepted with no responses (TAG_DEPTH = 4) -> the fifth request is held with ready = 0; in the cycle a mem_rsp arrives, ready = 1 and count stays 4.
REQ-030 Interleaved ids 1,0,1 outstanding, responses A, B, C -> rsp1 = A, rsp0 = B, rsp1 = C, in order; then rst asserted with 2 reads outstanding, 2 late mem_rsp -> no rspN_valid, count = 0.
